// File: rtl/gen_sched_pkg.sv
// Shared types and constants for the generator scheduler.
package gen_sched_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    ISSUE,
    WAIT_VALID,
    ERR
  } state_t;

  localparam logic SRC_FIB = 1'b0;
  localparam logic SRC_TMR = 1'b1;

  localparam logic [DATA_W-1:0] FIB_WRAP_DEF = 16'd46368;

endpackage

// File: rtl/gen_scheduler_if.sv
// Generator handshake and display bus between the scheduler and its clients.
interface gen_scheduler_if;
  import gen_sched_pkg::*;

  logic              f_en;
  logic              f_clr;
  logic              f_valid;
  logic [DATA_W-1:0] f_out;
  logic              t_en;
  logic              t_clr;
  logic              t_valid;
  logic [DATA_W-1:0] t_out;
  logic [DATA_W-1:0] disp_data;
  logic              disp_src;
  logic              disp_valid;
  logic              busy;
  logic              err;

  modport master (
    output f_en, f_clr, t_en, t_clr, disp_data, disp_src, disp_valid, busy, err,
    input  f_valid, f_out, t_valid, t_out
  );

  modport slave (
    input  f_en, f_clr, t_en, t_clr, disp_data, disp_src, disp_valid, busy, err,
    output f_valid, f_out, t_valid, t_out
  );

endinterface

// File: rtl/btn_rise.sv
// Rising-edge detector for a level input already synchronous to clk.
module btn_rise (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rising
);

  logic prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev <= 1'b0;
    else      prev <= din;
  end

  assign rising = din & ~prev;

endmodule

// File: rtl/gen_scheduler.sv
// Paces the fibonacci and timer generators on a divided tick and shares one
// registered display path between them, with run/pause, source select and a watchdog.
module gen_scheduler
  import gen_sched_pkg::*;
#(
  parameter int unsigned       TICK_DIV = 5_000_000,
  parameter int unsigned       TIMEOUT  = 1024,
  parameter logic [DATA_W-1:0] FIB_WRAP = FIB_WRAP_DEF
) (
  input logic             clk,
  input logic             rst,
  input logic             run_btn,
  input logic             sel_btn,
  gen_scheduler_if.master bus
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);

  state_t state, state_nxt;

  logic run_rise, sel_rise_raw, sel_rise;
  logic running, tick;
  logic [TICK_W-1:0] tick_cnt;
  logic [WD_W-1:0]   wd_cnt;
  logic wrap_issue, cur_valid;
  logic [DATA_W-1:0] cur_out;

  logic f_en_q, f_clr_q, t_en_q, t_clr_q, disp_valid_q, disp_src_q, busy_q, err_q;
  logic f_en_d, f_clr_d, t_en_d, t_clr_d, disp_valid_d, disp_src_d, busy_d, err_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic sel_pending, sel_pending_d, wrap_pending, wrap_pending_d;

  btn_rise u_run_rise (.clk(clk), .rst(rst), .din(run_btn), .rising(run_rise));
  btn_rise u_sel_rise (.clk(clk), .rst(rst), .din(sel_btn), .rising(sel_rise_raw));

  // A run edge always wins over a simultaneous select edge.
  assign sel_rise = sel_rise_raw & ~run_rise;

  assign running    = (state == WAIT_TICK) || (state == ISSUE) || (state == WAIT_VALID);
  assign tick       = running && (tick_cnt == TICK_LAST);
  assign wrap_issue = (disp_src_q == SRC_FIB) && wrap_pending;
  assign cur_valid  = (disp_src_q == SRC_TMR) ? bus.t_valid : bus.f_valid;
  assign cur_out    = (disp_src_q == SRC_TMR) ? bus.t_out   : bus.f_out;

  // Tick divider; held at zero while stopped so the first tick is a full period after run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       tick_cnt <= '0;
    else if (!running || tick)      tick_cnt <= '0;
    else                            tick_cnt <= tick_cnt + TICK_W'(1);
  end

  // Watchdog counts from the strobe cycle onward.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                         wd_cnt <= '0;
    else if ((state == ISSUE) || (state == WAIT_VALID)) wd_cnt <= wd_cnt + WD_W'(1);
    else                                              wd_cnt <= '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (run_rise) state_nxt = WAIT_TICK;
      WAIT_TICK: begin
        if (run_rise)                          state_nxt = IDLE;
        else if (!(sel_rise || sel_pending) && tick) state_nxt = ISSUE;
      end
      ISSUE:      state_nxt = wrap_issue ? WAIT_TICK : WAIT_VALID;
      WAIT_VALID: begin
        if (run_rise)               state_nxt = IDLE;
        else if (cur_valid)         state_nxt = WAIT_TICK;
        else if (wd_cnt == WD_LAST) state_nxt = ERR;
      end
      ERR:        if (run_rise) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Next values for every registered output and the pending flags.
  always_comb begin
    f_en_d         = 1'b0;
    f_clr_d        = 1'b0;
    t_en_d         = 1'b0;
    t_clr_d        = 1'b0;
    disp_valid_d   = 1'b0;
    disp_data_d    = disp_data_q;
    disp_src_d     = disp_src_q;
    sel_pending_d  = sel_pending;
    wrap_pending_d = wrap_pending;
    busy_d         = (state_nxt != IDLE) && (state_nxt != ERR);
    err_d          = (state_nxt == ERR);
    case (state)
      IDLE: if (sel_rise) disp_src_d = ~disp_src_q;
      WAIT_TICK: begin
        if (!run_rise) begin
          if (sel_rise || sel_pending) begin
            disp_src_d    = ~disp_src_q;
            sel_pending_d = 1'b0;
          end else if (tick) begin
            if (wrap_issue)                   f_clr_d = 1'b1;
            else if (disp_src_q == SRC_TMR)   t_en_d  = 1'b1;
            else                              f_en_d  = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (sel_rise) sel_pending_d = 1'b1;
        if (wrap_issue) begin
          disp_data_d    = '0;
          disp_valid_d   = 1'b1;
          wrap_pending_d = 1'b0;
        end
      end
      WAIT_VALID: begin
        if (!run_rise) begin
          if (sel_rise) sel_pending_d = 1'b1;
          if (cur_valid) begin
            disp_data_d  = cur_out;
            disp_valid_d = 1'b1;
            if ((disp_src_q == SRC_FIB) && (bus.f_out == FIB_WRAP)) wrap_pending_d = 1'b1;
          end
        end
      end
      ERR: begin
        if (run_rise) begin
          f_clr_d        = 1'b1;
          t_clr_d        = 1'b1;
          wrap_pending_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_en_q       <= 1'b0;
      f_clr_q      <= 1'b0;
      t_en_q       <= 1'b0;
      t_clr_q      <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_src_q   <= SRC_FIB;
      disp_data_q  <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      sel_pending  <= 1'b0;
      wrap_pending <= 1'b0;
    end else begin
      f_en_q       <= f_en_d;
      f_clr_q      <= f_clr_d;
      t_en_q       <= t_en_d;
      t_clr_q      <= t_clr_d;
      disp_valid_q <= disp_valid_d;
      disp_src_q   <= disp_src_d;
      disp_data_q  <= disp_data_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      sel_pending  <= sel_pending_d;
      wrap_pending <= wrap_pending_d;
    end
  end

  assign bus.f_en       = f_en_q;
  assign bus.f_clr      = f_clr_q;
  assign bus.t_en       = t_en_q;
  assign bus.t_clr      = t_clr_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.disp_src   = disp_src_q;
  assign bus.disp_data  = disp_data_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_gen_scheduler.sv
// Directed bench for gen_scheduler with small fibonacci and timer generator models.
module tb_gen_scheduler;

  logic clk, rst, run_btn, sel_btn;
  gen_scheduler_if bus ();

  gen_scheduler #(.TICK_DIV(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .run_btn(run_btn), .sel_btn(sel_btn), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors, miscompares;

  // Generator models: answer two cycles after a strobe.
  logic        f_respond, t_inject, f_fire, t_fire;
  logic [15:0] fa, fb, fnext, fval, tcnt, tval;
  int          fpend, tpend;

  always @(negedge clk) begin
    f_fire = 1'b0;
    t_fire = 1'b0;
    if (!rst) begin
      fa = 16'd0; fb = 16'd1; fval = 16'd0; fpend = 0;
      tcnt = 16'd0; tval = 16'd0; tpend = 0;
    end else begin
      if (fpend > 0) begin fpend--; if (fpend == 0) f_fire = 1'b1; end
      if (tpend > 0) begin tpend--; if (tpend == 0) t_fire = 1'b1; end
      if (bus.f_clr) begin fa = 16'd0; fb = 16'd1; end
      if (bus.t_clr) tcnt = 16'd0;
      if (bus.f_en && f_respond) begin
        fval = fa; fnext = fa + fb; fa = fb; fb = fnext; fpend = 2;
      end
      if (bus.t_en) begin tcnt = tcnt + 16'd1; tval = 16'h1000 | tcnt; tpend = 2; end
    end
  end

  assign bus.f_valid = f_fire;
  assign bus.f_out   = fval;
  assign bus.t_valid = t_fire | t_inject;
  assign bus.t_out   = t_inject ? 16'hBEEF : tval;

  logic [3:0]  strb;
  logic [23:0] outs;
  logic [17:0] disp;
  assign strb = {bus.f_en, bus.f_clr, bus.t_en, bus.t_clr};
  assign outs = {strb, bus.disp_valid, bus.disp_src, bus.busy, bus.err, bus.disp_data};
  assign disp = {bus.disp_valid, bus.disp_src, bus.disp_data};

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe(input string tag, input logic [3:0] exp);
    int n = 0;
    while (strb == 4'b0 && n < 20) begin step(); n++; end
    chk(tag, 32'(strb), 32'(exp));
  endtask

  task automatic do_reset();
    rst = 1'b0; step(); step(); rst = 1'b1; step();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1);
  end

  logic [15:0] ea, eb, en;
  int seen;

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b0; run_btn = 1'b0; sel_btn = 1'b0; f_respond = 1'b1; t_inject = 1'b0;
    step(); step();
    chk("reset_outs", 32'(outs), 32'h0);
    rst = 1'b1; step();
    chk("idle_after_reset", 32'(outs), 32'h0);

    // 1: fibonacci 0,1,1,2 paced every 4 cycles
    run_btn = 1'b1; step(); run_btn = 1'b0;
    chk("t1_busy", 32'(bus.busy), 32'h1);
    repeat (3) step();
    chk("t1_no_early_strobe", 32'(strb), 32'h0);
    step();
    ea = 16'd0; eb = 16'd1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_fen_%0d", i), 32'(strb), 32'h8);
      repeat (3) step();
      chk($sformatf("t1_disp_%0d", i), 32'(disp), 32'({2'b10, ea}));
      en = ea + eb; ea = eb; eb = en;
      step();
      chk($sformatf("t1_single_valid_%0d", i), 32'(bus.disp_valid), 32'h0);
    end

    // 2: select edge during WAIT_VALID
    chk("t2_fen", 32'(strb), 32'h8);
    step(); sel_btn = 1'b1; step(); sel_btn = 1'b0; step();
    chk("t2_fib_accepted", 32'(disp), 32'({2'b10, 16'd3}));
    step();
    chk("t2_src_toggled", 32'(bus.disp_src), 32'h1);
    wait_strobe("t2_ten", 4'b0010);
    repeat (3) step();
    chk("t2_timer_disp", 32'(disp), 32'({2'b11, 16'h1001}));

    // 3: run fibonacci to the 16-bit wrap
    do_reset();
    run_btn = 1'b1; step(); run_btn = 1'b0; repeat (4) step();
    ea = 16'd0; eb = 16'd1;
    for (int i = 0; i < 25; i++) begin
      chk($sformatf("t3_fen_%0d", i), 32'(strb), 32'h8);
      repeat (3) step();
      chk($sformatf("t3_disp_%0d", i), 32'(disp), 32'({2'b10, ea}));
      en = ea + eb; ea = eb; eb = en;
      step();
    end
    chk("t3_last_value", 32'(bus.disp_data), 32'd46368);
    chk("t3_fclr_strobe", 32'(strb), 32'h4);
    step();
    chk("t3_wrap_disp", 32'(disp), 32'({2'b10, 16'd0}));
    repeat (3) step();
    chk("t3_fen_after_wrap", 32'(strb), 32'h8);
    repeat (3) step();
    chk("t3_disp_after_wrap", 32'(disp), 32'({2'b10, 16'd0}));

    // 4: watchdog
    do_reset();
    f_respond = 1'b0;
    run_btn = 1'b1; step(); run_btn = 1'b0; repeat (4) step();
    chk("t4_fen", 32'(strb), 32'h8);
    repeat (7) step();
    chk("t4_not_yet_err", 32'({bus.err, bus.busy}), 32'h1);
    step();
    chk("t4_err", 32'({bus.err, bus.busy}), 32'h2);
    step();
    chk("t4_err_sticky", 32'(bus.err), 32'h1);
    run_btn = 1'b1; step(); run_btn = 1'b0;
    chk("t4_err_exit", 32'({strb, bus.err, bus.busy}), 32'h14);
    step();
    chk("t4_clr_one_cycle", 32'(strb), 32'h0);
    repeat (6) step();
    chk("t4_idle", 32'({strb, bus.busy}), 32'h0);
    f_respond = 1'b1;

    // 5: simultaneous run/sel, foreign valid ignored
    run_btn = 1'b1; sel_btn = 1'b1; step(); run_btn = 1'b0; sel_btn = 1'b0;
    chk("t5_run_wins", 32'({bus.busy, bus.disp_src}), 32'h2);
    repeat (4) step();
    chk("t5_fen", 32'(strb), 32'h8);
    step(); t_inject = 1'b1; step(); t_inject = 1'b0;
    chk("t5_tvalid_ignored", 32'(bus.disp_valid), 32'h0);
    step();
    chk("t5_fib_disp", 32'(disp), 32'({2'b10, 16'd0}));

    // 6: reset during WAIT_VALID
    step();
    chk("t6_fen", 32'(strb), 32'h8);
    repeat (3) step();
    chk("t6_disp", 32'(disp), 32'({2'b10, 16'd1}));
    repeat (2) step();
    chk("t6_busy_before_rst", 32'(bus.busy), 32'h1);
    rst = 1'b0; #1;
    chk("t6_async_clear", 32'(outs), 32'h0);
    step(); step(); rst = 1'b1;
    seen = 0;
    repeat (12) begin step(); if (strb != 4'b0) seen++; end
    chk("t6_no_strobe", 32'(seen), 32'h0);
    chk("t6_idle", 32'(bus.busy), 32'h0);
    run_btn = 1'b1; step(); run_btn = 1'b0; repeat (4) step();
    chk("t6_restart_fen", 32'(strb), 32'h8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
